// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser: FSM state encoding,
// default sync bytes and err_code values.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN,
    ST_CMD,
    ST_DATA,
    ST_CHK
  } state_t;

  localparam logic [7:0] HDR0_DEF = 8'h55;
  localparam logic [7:0] HDR1_DEF = 8'hAA;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/frame_timer.sv
// Inter-byte timeout counter: clears on clr, counts while en, and flags
// expiry when the count reaches TIMEOUT_CYC-1.
module frame_timer #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic clk_50,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT_CYC) + 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = en && (cnt == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_frame_parser.sv
// Parses HDR0 HDR1 LEN CMD payload CHK frames from a UART byte stream and
// commits good frames to a readable payload buffer.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  HDR0        = HDR0_DEF,
  parameter logic [7:0]  HDR1        = HDR1_DEF,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [7:0] cmd,
  output logic [4:0] frame_len,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned DEPTH = 16;

  state_t     state, state_nxt;
  logic [4:0] len_q;
  logic [4:0] idx_q;
  logic [7:0] sum_q;
  logic [7:0] cmd_w;
  logic [7:0] wbuf [DEPTH];
  logic [7:0] cbuf [DEPTH];

  logic       ok_d, err_d, commit;
  logic [1:0] code_d;
  logic       expired;

  frame_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk_50  (clk_50),
    .rst_n   (rst_n),
    .clr     (rx_valid || (state == ST_IDLE)),
    .en      (state != ST_IDLE),
    .expired (expired)
  );

  // A received byte always wins over a coincident timeout expiry.
  always_comb begin
    state_nxt = state;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = ERR_NONE;
    commit    = 1'b0;
    if (rx_valid) begin
      unique case (state)
        ST_IDLE: if (rx_data == HDR0) state_nxt = ST_SYNC;
        ST_SYNC: begin
          if (rx_data == HDR1)      state_nxt = ST_LEN;
          else if (rx_data == HDR0) state_nxt = ST_SYNC;
          else                      state_nxt = ST_IDLE;
        end
        ST_LEN: begin
          if (32'(rx_data) > MAX_LEN) begin
            err_d     = 1'b1;
            code_d    = ERR_LEN;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_CMD;
          end
        end
        ST_CMD:  state_nxt = (len_q == '0) ? ST_CHK : ST_DATA;
        ST_DATA: if (idx_q + 5'd1 == len_q) state_nxt = ST_CHK;
        ST_CHK: begin
          if (rx_data == sum_q) begin
            ok_d   = 1'b1;
            commit = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CHK;
          end
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (expired) begin
      err_d     = 1'b1;
      code_d    = ERR_TIMEOUT;
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_nxt;
      frame_ok  <= ok_d;
      frame_err <= err_d;
      if (err_d) err_code <= code_d;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      cmd_w     <= '0;
      cmd       <= '0;
      frame_len <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        wbuf[i] <= '0;
        cbuf[i] <= '0;
      end
    end else begin
      if (rx_valid) begin
        unique case (state)
          ST_LEN: begin
            len_q <= rx_data[4:0];
            sum_q <= rx_data;
            idx_q <= '0;
          end
          ST_CMD: begin
            cmd_w <= rx_data;
            sum_q <= sum_q + rx_data;
          end
          ST_DATA: begin
            wbuf[idx_q[3:0]] <= rx_data;
            idx_q            <= idx_q + 5'd1;
            sum_q            <= sum_q + rx_data;
          end
          default: ;
        endcase
      end
      if (commit) begin
        cbuf      <= wbuf;
        cmd       <= cmd_w;
        frame_len <= len_q;
      end
    end
  end

  assign rd_data = cbuf[rd_addr];
  assign busy    = (state != ST_IDLE);

endmodule
